// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle KGP-RISC control FSM (FETCH/DECODE/EXEC/MEM/WB) with one handshaked memory port
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   run               level; 1 = execute, 0 = park in IDLE at the next instruction boundary
//   opcode            IR[31:26], latched in DECODE
//   mem_ready         memory completes the current request this cycle
//   mem_req/mem_we    memory request (held until mem_ready) and write qualifier
//   mem_addr_sel      0 = PC, 1 = ALU result
//   ir_write/pc_write IR load and PC+4 pulses on fetch completion
//   branch_en         branch/jump resolve strobe
//   reg_write         register-file write strobe
//   reg_dst/mem2reg   writeback register and data selects
//   alu_src/lbl_sel/jmp_sel  datapath operand and branch-target selects
//   busy/fault        activity and sticky fault flags
//   instr_count       retired instructions, wraps
//
// Parameters: MEM_TIMEOUT (0 disables the memory timeout), CNT_W.
// Build option: define ILLEGAL_TRAP_EN to send unlisted opcodes to FAULT instead of retiring them as NOPs.
module mc_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch_en,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem2reg,
  output logic             alu_src,
  output logic             lbl_sel,
  output logic             jmp_sel,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT} state_t;
  localparam int WW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT == 0 ? 0 : MEM_TIMEOUT - 1);
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  state_t state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic is_r, is_addi, is_cmpi, is_lw, is_sw, is_b, is_lbl, is_br, is_bl, legal, timeout;
  state_t ret_s;
  assign is_r    = opcode_q == 6'b000000;
  assign is_addi = opcode_q == 6'b001000;
  assign is_cmpi = opcode_q == 6'b001001;
  assign is_lw   = opcode_q == 6'b010000;
  assign is_sw   = opcode_q == 6'b011000;
  assign is_b    = opcode_q == 6'b101000 || opcode_q == 6'b101001 || opcode_q == 6'b101010;
  assign is_lbl  = opcode_q[5:3] == 3'b110;
  assign is_br   = opcode_q == 6'b100000;
  assign is_bl   = opcode_q == 6'b101011;
  assign legal   = is_r | is_addi | is_cmpi | is_lw | is_sw | is_b | is_lbl | is_br | is_bl;
  // A stalled request faults on the cycle that would be its MEM_TIMEOUT-th wait; ready in that cycle wins.
  assign timeout = MEM_TIMEOUT != 0 && !mem_ready && wait_q == WAIT_LAST;
  assign ret_s   = run ? FETCH : IDLE;
  assign busy    = state_q != IDLE && state_q != FAULT;
  assign fault   = state_q == FAULT;
  assign instr_count = cnt_q;
  always_comb begin
    state_d = state_q;
    opcode_d = opcode_q;
    wait_d = '0;
    cnt_d = cnt_q;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    branch_en = 1'b0;
    reg_write = 1'b0;
    reg_dst = 2'b00;
    mem2reg = 2'b00;
    alu_src = 1'b0;
    lbl_sel = 1'b0;
    jmp_sel = 1'b0;
    case (state_q)
      IDLE: state_d = run ? FETCH : IDLE;
      FETCH: begin
        mem_req = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        wait_d = mem_ready ? '0 : wait_q + 1'b1;
        state_d = mem_ready ? DECODE : timeout ? FAULT : FETCH;
      end
      DECODE: begin
        opcode_d = opcode;
        state_d = EXEC;
      end
      EXEC: begin
        alu_src = is_addi | is_cmpi | is_lw | is_sw;
        branch_en = is_b | is_lbl | is_br | is_bl;
        lbl_sel = is_lbl;
        jmp_sel = is_br;
        reg_write = is_bl;
        reg_dst = is_bl ? 2'b11 : 2'b00;
        if (is_r || is_addi || is_cmpi) state_d = WB;
        else if (is_lw || is_sw) state_d = MEM;
        else if (TRAP && !legal) state_d = FAULT;
        else begin
          state_d = ret_s;
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_addr_sel = 1'b1;
        alu_src = 1'b1;
        mem_we = is_sw;
        wait_d = mem_ready ? '0 : wait_q + 1'b1;
        state_d = mem_ready ? (is_lw ? WB : ret_s) : timeout ? FAULT : MEM;
        cnt_d = mem_ready && !is_lw ? cnt_q + 1'b1 : cnt_q;
      end
      WB: begin
        reg_write = 1'b1;
        mem2reg = is_lw ? 2'b01 : 2'b11;
        alu_src = is_addi | is_cmpi | is_lw;
        state_d = ret_s;
        cnt_d = cnt_q + 1'b1;
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opcode_q <= '0;
      wait_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      opcode_q <= opcode_d;
      wait_q <= wait_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: table-driven directed bench for mc_sequencer
module tb_mc_sequencer;
  localparam logic [15:0] REQ = 16'h8000, WE = 16'h4000, AS = 16'h2000, IRW = 16'h1000,
    PCW = 16'h0800, BEN = 16'h0400, RW = 16'h0200, RD_LINK = 16'h0180, M2R_MEM = 16'h0020,
    M2R_ALU = 16'h0060, ALU = 16'h0010, LBL = 16'h0008, JMP = 16'h0004, BSY = 16'h0002,
    FLT = 16'h0001;
  localparam logic [15:0] FET = REQ | IRW | PCW | BSY;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b010000,
    OP_SW = 6'b011000, OP_BL = 6'b101011, OP_BZ = 6'b110001, OP_BR = 6'b100000,
    OP_BCY = 6'b101001, OP_ILL = 6'b111111;
  typedef struct {
    logic r;
    logic ru;
    logic [5:0] op;
    logic rd;
    logic [15:0] e;
    int unsigned c;
  } vec_t;
  logic clk, rst, run, mem_ready;
  logic [5:0] opcode;
  logic mem_req, mem_we, mem_addr_sel, ir_write, pc_write, branch_en, reg_write;
  logic alu_src, lbl_sel, jmp_sel, busy, fault;
  logic [1:0] reg_dst, mem2reg;
  logic [31:0] instr_count;
  logic [15:0] outs;
  int n_cmp, n_bad;
  vec_t tv[$];
  mc_sequencer #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .branch_en(branch_en), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem2reg(mem2reg), .alu_src(alu_src), .lbl_sel(lbl_sel), .jmp_sel(jmp_sel),
    .busy(busy), .fault(fault), .instr_count(instr_count)
  );
  assign outs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, branch_en, reg_write,
                 reg_dst, mem2reg, alu_src, lbl_sel, jmp_sel, busy, fault};
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic void v(input logic r, input logic ru, input logic [5:0] op,
                            input logic rd, input logic [15:0] e, input int unsigned c);
    vec_t t;
    t.r = r; t.ru = ru; t.op = op; t.rd = rd; t.e = e; t.c = c;
    tv.push_back(t);
  endfunction
  task automatic step(input logic r, input logic ru, input logic [5:0] op, input logic rd,
                      input logic [15:0] e, input int unsigned c, input string nm);
    @(negedge clk);
    rst = r; run = ru; opcode = op; mem_ready = rd;
    #1;
    n_cmp++;
    if (outs !== e || instr_count !== c) begin
      n_bad++;
      $display("FAIL %s: got outs=%h count=%0d, expected outs=%h count=%0d", nm, outs, instr_count, e, c);
    end
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; run = 1'b0; opcode = OP_R; mem_ready = 1'b0;
    v(1, 0, OP_R, 0, 16'h0, 0);
    v(0, 0, OP_R, 0, 16'h0, 0);
    v(0, 0, OP_R, 0, 16'h0, 0);
    v(0, 1, OP_R, 1, 16'h0, 0);
    v(0, 1, OP_R, 1, FET, 0);
    v(0, 1, OP_R, 1, BSY, 0);
    v(0, 1, OP_R, 1, BSY, 0);
    v(0, 1, OP_R, 1, RW | M2R_ALU | BSY, 0);
    v(0, 1, OP_LW, 1, FET, 1);
    v(0, 1, OP_LW, 1, BSY, 1);
    v(0, 1, OP_LW, 1, ALU | BSY, 1);
    v(0, 1, OP_LW, 0, REQ | AS | ALU | BSY, 1);
    v(0, 1, OP_LW, 0, REQ | AS | ALU | BSY, 1);
    v(0, 1, OP_LW, 0, REQ | AS | ALU | BSY, 1);
    v(0, 1, OP_LW, 1, REQ | AS | ALU | BSY, 1);
    v(0, 1, OP_LW, 1, RW | M2R_MEM | ALU | BSY, 1);
    v(0, 1, OP_BL, 1, FET, 2);
    v(0, 1, OP_BL, 1, BSY, 2);
    v(0, 1, OP_BL, 1, BEN | RW | RD_LINK | BSY, 2);
    v(0, 1, OP_SW, 1, FET, 3);
    v(0, 1, OP_SW, 1, BSY, 3);
    v(0, 1, OP_SW, 1, ALU | BSY, 3);
    v(0, 1, OP_SW, 1, REQ | WE | AS | ALU | BSY, 3);
    v(0, 1, OP_BZ, 1, FET, 4);
    v(0, 1, OP_BZ, 1, BSY, 4);
    v(0, 1, OP_BZ, 1, BEN | LBL | BSY, 4);
    v(0, 1, OP_BR, 1, FET, 5);
    v(0, 1, OP_BR, 1, BSY, 5);
    v(0, 1, OP_BR, 1, BEN | JMP | BSY, 5);
    v(0, 1, OP_BCY, 1, FET, 6);
    v(0, 1, OP_BCY, 1, BSY, 6);
    v(0, 0, OP_BCY, 1, BEN | BSY, 6);
    v(0, 0, OP_BCY, 1, 16'h0, 7);
    v(0, 1, OP_BCY, 1, 16'h0, 7);
    v(0, 1, OP_ADDI, 0, REQ | BSY, 7);
    v(0, 0, OP_ADDI, 1, FET, 7);
    v(0, 0, OP_ADDI, 1, BSY, 7);
    v(0, 0, OP_ADDI, 1, ALU | BSY, 7);
    v(0, 0, OP_ADDI, 1, RW | M2R_ALU | ALU | BSY, 7);
    v(0, 0, OP_ADDI, 1, 16'h0, 8);
    @(posedge clk);
    for (int i = 0; i < tv.size(); i++)
      step(tv[i].r, tv[i].ru, tv[i].op, tv[i].rd, tv[i].e, tv[i].c, $sformatf("vec%0d", i));
    // fetch timeout: four stalled cycles then FAULT, sticky until reset
    step(0, 1, OP_R, 0, 16'h0, 8, "to_idle");
    for (int i = 0; i < 4; i++) step(0, 1, OP_R, 0, REQ | BSY, 8, $sformatf("to_wait%0d", i));
    step(0, 1, OP_R, 1, FLT, 8, "to_fault");
    step(0, 1, OP_R, 1, FLT, 8, "to_sticky");
    step(1, 0, OP_R, 0, FLT, 8, "to_rst");
    step(0, 0, OP_R, 0, 16'h0, 0, "to_cleared");
    // reset asserted during a stalled MEM access
    step(0, 1, OP_LW, 1, 16'h0, 0, "rm_idle");
    step(0, 1, OP_LW, 1, FET, 0, "rm_fetch");
    step(0, 1, OP_LW, 1, BSY, 0, "rm_dec");
    step(0, 1, OP_LW, 1, ALU | BSY, 0, "rm_exec");
    step(1, 1, OP_LW, 0, REQ | AS | ALU | BSY, 0, "rm_mem");
    step(0, 0, OP_LW, 1, 16'h0, 0, "rm_after");
    // unlisted opcode
    step(0, 1, OP_ILL, 1, 16'h0, 0, "il_idle");
    step(0, 1, OP_ILL, 1, FET, 0, "il_fetch");
    step(0, 1, OP_ILL, 1, BSY, 0, "il_dec");
    step(0, 0, OP_ILL, 1, BSY, 0, "il_exec");
`ifdef ILLEGAL_TRAP_EN
    step(0, 0, OP_ILL, 1, FLT, 0, "il_trap");
`else
    step(0, 0, OP_ILL, 1, 16'h0, 1, "il_nop");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
